// File: rtl/iwanna_soc_keyfifo.sv
// iwanna_soc_keyfifo: Avalon-MM keycode FIFO with a streaming head output,
// sticky overflow/drained flags and a level interrupt.
module iwanna_soc_keyfifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rptr, wptr;
    logic [AW:0]       level;
    logic              ovf, drained, irq_en;
    logic              wr, data_wr, status_wr, ctrl_wr, flush;
    logic              empty, full, pop, push, ovf_set, drained_set;
    logic [31:0]       status;

    assign wr        = chipselect & ~write_n;
    assign data_wr   = wr & (address == 2'd0);
    assign status_wr = wr & (address == 2'd1);
    assign ctrl_wr   = wr & (address == 2'd2);
    assign flush     = ctrl_wr & writedata[1];
    assign empty     = level == '0;
    assign full      = level == (AW+1)'(DEPTH);
    assign out_valid = ~empty;
    assign out_data  = mem[rptr];
    assign pop       = out_valid & out_ready & ~flush;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the write.
    assign push        = data_wr & (~full | pop) & ~flush;
    assign ovf_set     = data_wr & full & ~pop & ~flush;
    assign drained_set = pop & ~push & (level == (AW+1)'(1));
    assign status      = {12'd0, drained, ovf, full, empty, 16'(level)};
    assign irq         = irq_en & (drained | ovf);
    assign readdata    = (address == 2'd0) ? (empty ? 32'd0 : 32'(out_data)) :
                         (address == 2'd1) ? status :
                         (address == 2'd2) ? {31'd0, irq_en} : 32'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr    <= '0;
            wptr    <= '0;
            level   <= '0;
            ovf     <= 1'b0;
            drained <= 1'b0;
            irq_en  <= 1'b0;
        end else begin
            rptr    <= flush ? '0 : pop ? rptr + AW'(1) : rptr;
            wptr    <= flush ? '0 : push ? wptr + AW'(1) : wptr;
            level   <= flush ? '0 : (push & ~pop) ? level + (AW+1)'(1) :
                       (pop & ~push) ? level - (AW+1)'(1) : level;
            ovf     <= ovf_set | (ovf & ~(status_wr & writedata[18]));
            drained <= drained_set | (drained & ~(status_wr & writedata[19]));
            if (ctrl_wr)
                irq_en <= writedata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= writedata[DATA_W-1:0];
    end
endmodule

// File: tb/tb_iwanna_soc_keyfifo.sv
// tb_iwanna_soc_keyfifo: vector table, corner sequences and a queue-model random run.
module tb_iwanna_soc_keyfifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        irq;
    int          total = 0;
    int          bad = 0;

    iwanna_soc_keyfifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [1:0]  a;
        logic [31:0] wd;
        logic        r;
        logic [31:0] st;
        logic        v;
        logic [31:0] d;
        logic        irq;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d, input logic r);
        chipselect = w;
        write_n = ~w;
        address = a;
        writedata = d;
        out_ready = r;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
        out_ready = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic do_reset();
        chipselect = 1'b0;
        write_n = 1'b1;
        out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] mstat(input int n, input bit o, input bit dr);
        return 32'(n) | (n == 0 ? 32'h10000 : 32'h0) | (n == 16 ? 32'h20000 : 32'h0) |
               (o ? 32'h40000 : 32'h0) | (dr ? 32'h80000 : 32'h0);
    endfunction

    initial begin
        logic [31:0] s;
        int          q[$];
        bit          m_ovf, m_dr, m_ien;

        tv[0]  = '{1'b1, 2'd0, 32'h1D2,      1'b0, 32'h00000001, 1'b1, 32'hD2, 1'b0};
        tv[1]  = '{1'b1, 2'd0, 32'h0A5,      1'b0, 32'h00000002, 1'b1, 32'hD2, 1'b0};
        tv[2]  = '{1'b0, 2'd0, 32'h0,        1'b1, 32'h00000001, 1'b1, 32'hA5, 1'b0};
        tv[3]  = '{1'b0, 2'd0, 32'h0,        1'b1, 32'h00090000, 1'b0, 32'h00, 1'b0};
        tv[4]  = '{1'b1, 2'd1, 32'h00080000, 1'b0, 32'h00010000, 1'b0, 32'h00, 1'b0};
        tv[5]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 1'b0, 32'h00010000, 1'b0, 32'h00, 1'b0};
        tv[6]  = '{1'b1, 2'd2, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 32'h00, 1'b0};
        tv[7]  = '{1'b1, 2'd0, 32'h033,      1'b1, 32'h00000001, 1'b1, 32'h33, 1'b0};
        tv[8]  = '{1'b0, 2'd0, 32'h0,        1'b1, 32'h00090000, 1'b0, 32'h00, 1'b1};
        tv[9]  = '{1'b1, 2'd1, 32'h00040000, 1'b0, 32'h00090000, 1'b0, 32'h00, 1'b1};
        tv[10] = '{1'b1, 2'd2, 32'h00000000, 1'b0, 32'h00090000, 1'b0, 32'h00, 1'b0};
        tv[11] = '{1'b1, 2'd1, 32'h00080000, 1'b0, 32'h00010000, 1'b0, 32'h00, 1'b0};

        do_reset();
        rd(2'd1, s); chk("reset_status", s, 32'h00010000);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        rd(2'd2, s); chk("reset_ctrl", s, 32'd0);
        rd(2'd3, s); chk("reset_rsvd", s, 32'd0);

        for (int i = 0; i < 12; i++) begin
            cyc(tv[i].w, tv[i].a, tv[i].wd, tv[i].r);
            rd(2'd1, s); chk($sformatf("vec%0d_status", i), s, tv[i].st);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tv[i].v));
            rd(2'd0, s); chk($sformatf("vec%0d_data", i), s, tv[i].d);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tv[i].irq));
        end
        rd(2'd2, s); chk("ctrl_readback", s, 32'd0);

        // overflow: 17th write dropped and absent from drain order
        do_reset();
        for (int i = 1; i <= 17; i++) cyc(1'b1, 2'd0, 32'(i), 1'b0);
        rd(2'd1, s); chk("ovf_status", s, 32'h00060010);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("ovf_drain%0d", i), 32'(out_data), 32'(i));
            cyc(1'b0, 2'd0, 32'd0, 1'b1);
        end
        chk("ovf_empty", 32'(out_valid), 32'd0);
        rd(2'd1, s); chk("ovf_drained_status", s, 32'h000D0000);

        // full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 2'd0, 32'h40 + 32'(i), 1'b0);
        cyc(1'b1, 2'd0, 32'h99, 1'b1);
        rd(2'd1, s); chk("fullpp_status", s, 32'h00020010);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("fullpp_drain%0d", i), 32'(out_data), i == 16 ? 32'h99 : 32'h40 + 32'(i));
            cyc(1'b0, 2'd0, 32'd0, 1'b1);
        end
        chk("fullpp_empty", 32'(out_valid), 32'd0);

        // irq on drain of two entries, cleared by W1C
        do_reset();
        cyc(1'b1, 2'd2, 32'h1, 1'b0);
        cyc(1'b1, 2'd0, 32'h11, 1'b0);
        cyc(1'b1, 2'd0, 32'h22, 1'b0);
        cyc(1'b0, 2'd0, 32'd0, 1'b1);
        chk("irq_after_pop1", 32'(irq), 32'd0);
        cyc(1'b0, 2'd0, 32'd0, 1'b1);
        chk("irq_after_pop2", 32'(irq), 32'd1);
        cyc(1'b1, 2'd1, 32'h00080000, 1'b0);
        chk("irq_cleared", 32'(irq), 32'd0);

        // drained set wins over same-cycle W1C
        cyc(1'b1, 2'd0, 32'h5, 1'b0);
        cyc(1'b1, 2'd1, 32'h00080000, 1'b1);
        rd(2'd1, s); chk("setwins_status", s, 32'h00090000);

        // flush with same-cycle pop
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 32'(i), 1'b0);
        cyc(1'b1, 2'd2, 32'h3, 1'b1);
        rd(2'd1, s); chk("flush_status", s, 32'h00010000);
        chk("flush_valid", 32'(out_valid), 32'd0);
        rd(2'd2, s); chk("flush_ctrl", s, 32'd1);
        cyc(1'b1, 2'd0, 32'h77, 1'b0);
        rd(2'd0, s); chk("flush_after_push", s, 32'h77);

        // 20 entries through the ring
        do_reset();
        cyc(1'b1, 2'd0, 32'h80, 1'b0);
        for (int i = 1; i < 20; i++) begin
            chk($sformatf("wrap_head%0d", i), 32'(out_data), 32'h80 + 32'(i - 1));
            cyc(1'b1, 2'd0, 32'h80 + 32'(i), 1'b1);
        end
        rd(2'd1, s); chk("wrap_status", s, 32'h00000001);
        rd(2'd0, s); chk("wrap_last", s, 32'h93);

        // asynchronous reset mid-operation
        cyc(1'b1, 2'd0, 32'h1, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk("async_valid", 32'(out_valid), 32'd0);
        rd(2'd1, s); chk("async_status", s, 32'h00010000);
        do_reset();

        // randomized run against a queue model
        m_ovf = 0; m_dr = 0; m_ien = 0;
        for (int it = 0; it < 500; it++) begin
            int          k, n;
            logic        w, r;
            logic [1:0]  a;
            logic [31:0] wd;
            bit          fl, dw, pp, ps, os, ds;
            rd(2'd1, s); chk("rnd_status", s, mstat(q.size(), m_ovf, m_dr));
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("rnd_data", 32'(out_data), 32'(q[0]));
            chk("rnd_irq", 32'(irq), 32'(m_ien & (m_ovf | m_dr)));
            k  = $urandom_range(0, 99);
            w  = k < 70;
            a  = k < 50 ? 2'd0 : k < 62 ? 2'd1 : k < 66 ? 2'd2 : k < 70 ? 2'd3 : 2'($urandom_range(0, 3));
            wd = $urandom;
            r  = $urandom_range(0, 99) < 35;
            n  = q.size();
            fl = w && a == 2'd2 && wd[1];
            dw = w && a == 2'd0;
            pp = r && n > 0 && !fl;
            ps = dw && (n < 16 || pp);
            os = dw && n == 16 && !pp;
            ds = pp && !ps && n == 1;
            if (fl) q.delete();
            if (pp) void'(q.pop_front());
            if (ps) q.push_back(int'(wd[7:0]));
            if (w && a == 2'd1) begin
                if (wd[18]) m_ovf = 0;
                if (wd[19]) m_dr = 0;
            end
            m_ovf |= os;
            m_dr  |= ds;
            if (w && a == 2'd2) m_ien = wd[0];
            cyc(w, a, wd, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
